// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI leader transceiver.
package spi_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of the follower index; a single follower still needs one bit
    function automatic int ss_width(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_leader_transceiver_if.sv
// User-side word interface and SPI pins of the leader, bundled together.
interface spi_leader_transceiver_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SS     = 1
);
    localparam int SS_W = ss_width(NUM_SS);

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  send;
    logic                  cpol;
    logic                  cpha;
    logic [SS_W-1:0]       ss_sel;
    logic                  miso;
    logic                  sck;
    logic [NUM_SS-1:0]     ss_n;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;

    modport master (
        input  tx_data, send, cpol, cpha, ss_sel, miso,
        output sck, ss_n, mosi, rx_data, rx_valid, busy
    );

    modport slave (
        output tx_data, send, cpol, cpha, ss_sel, miso,
        input  sck, ss_n, mosi, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/spi_sck_tick.sv
// Enabled clock divider: one-cycle tick every CLK_DIV enabled cycles.
module spi_sck_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles, wrapping after CLK_DIV; restart realigns the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/spi_leader_transceiver.sv
// Full-duplex SPI leader: parallel word in, serial out, serial in, word out.
module spi_leader_transceiver
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 25,
    parameter int NUM_SS     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_leader_transceiver_if.master bus
);
    localparam int SS_W   = ss_width(NUM_SS);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

    state_t                state;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [NUM_SS-1:0]     ss_decode_n;
    logic                  tick;
    logic                  tick_en;
    logic                  accept;
    logic                  leading;
    logic                  last_edge;
    logic                  drive_leading;
    logic                  drive_now;
    logic                  sample_now;

    assign accept        = (state == IDLE) && bus.send;
    assign tick_en       = (state != IDLE);
    assign leading       = ~edge_cnt[0];
    assign last_edge     = (edge_cnt == EDGE_W'(2 * DATA_WIDTH - 1));
    assign drive_leading = (mode_q == MODE1) || (mode_q == MODE3);
    assign drive_now     = drive_leading ? leading : (~leading && ~last_edge);
    assign sample_now    = ((mode_q == MODE0) || (mode_q == MODE2)) ? leading : ~leading;

    spi_sck_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tick_en),
        .restart (accept),
        .tick    (tick)
    );

    // Out-of-range follower indices decode to no select at all
    always_comb begin
        ss_decode_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (bus.ss_sel == SS_W'(i)) begin
                ss_decode_n[i] = 1'b0;
            end
        end
    end

    // Transfer sequencer with registered SPI pins and word outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode_q       <= MODE0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            edge_cnt     <= '0;
            bus.sck      <= 1'b0;
            bus.ss_n     <= '1;
            bus.mosi     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send) begin
                        mode_q   <= {bus.cpol, bus.cpha};
                        bus.sck  <= bus.cpol;
                        bus.ss_n <= ss_decode_n;
                        bus.busy <= 1'b1;
                        edge_cnt <= '0;
                        if (!bus.cpha) begin
                            bus.mosi <= bus.tx_data[DATA_WIDTH-1];
                            tx_shift <= {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            tx_shift <= bus.tx_data;
                        end
                        state <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (tick) begin
                        bus.sck  <= ~bus.sck;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (drive_now) begin
                            bus.mosi <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sample_now) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.miso};
                        end
                        if (state == SETUP) begin
                            state <= SHIFT;
                        end else if (last_edge) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        bus.ss_n     <= '1;
                        bus.rx_data  <= rx_shift;
                        bus.rx_valid <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_leader_transceiver.sv
// Self-checking bench for spi_leader_transceiver in two configurations.
module tb_spi_leader_transceiver;
    import spi_pkg::*;

    localparam int WA = 8;
    localparam int HA = 4;
    localparam int NA = 4;
    localparam int WB = 16;
    localparam int HB = 2;
    localparam int NB = 1;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sel;
        logic [7:0] tx;
        logic [7:0] reply;
        logic       loop;
        logic [3:0] exp_ssn;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic       loop_a;
    logic [7:0] fa_reply;
    logic [7:0] fa_sh;
    logic [7:0] fa_rx;
    logic       fa_miso;
    logic       fa_cpha;

    spi_leader_transceiver_if #(.DATA_WIDTH(WA), .NUM_SS(NA)) bus_a ();
    spi_leader_transceiver_if #(.DATA_WIDTH(WB), .NUM_SS(NB)) bus_b ();

    spi_leader_transceiver #(.DATA_WIDTH(WA), .CLK_DIV(HA), .NUM_SS(NA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    spi_leader_transceiver #(.DATA_WIDTH(WB), .CLK_DIV(HB), .NUM_SS(NB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Follower side: either a wire loop from mosi, or the behavioural follower
    always_comb bus_a.miso = loop_a ? bus_a.mosi : fa_miso;
    always_comb bus_b.miso = bus_b.mosi;

    // Behavioural SPI follower: counts SCK edges while selected, per CPHA rules
    initial begin : follower_a
        logic prev_sel;
        logic prev_sck;
        logic sel;
        int   n;
        fa_miso  = 1'b0;
        fa_sh    = '0;
        fa_rx    = '0;
        prev_sel = 1'b0;
        prev_sck = 1'b0;
        n        = 0;
        forever begin
            @(bus_a.ss_n or bus_a.sck);
            sel = (bus_a.ss_n != 4'hF);
            if (sel && !prev_sel) begin
                n     = 0;
                fa_rx = '0;
                fa_sh = fa_reply;
                if (!fa_cpha) begin
                    fa_miso = fa_sh[7];
                    fa_sh   = {fa_sh[6:0], 1'b0};
                end
            end else if (sel && (bus_a.sck != prev_sck)) begin
                n++;
                if (((n % 2) == 1) != fa_cpha) begin
                    fa_rx = {fa_rx[6:0], bus_a.mosi};
                end else if (n < 2 * WA) begin
                    fa_miso = fa_sh[7];
                    fa_sh   = {fa_sh[6:0], 1'b0};
                end
            end
            prev_sel = sel;
            prev_sck = bus_a.sck;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete transfer on the 8-bit, 4-follower leader
    task automatic apply_stimulus_a(input logic [1:0] mode, input logic [1:0] sel, input logic [7:0] tx,
                                    input logic [7:0] reply, input logic loop, input logic [3:0] exp_ssn,
                                    input string tag);
        logic [7:0] exp_rx;
        logic       cp;
        logic       prev_sck;
        int         edges;
        int         pulses;
        int         pulse_k;
        exp_rx  = loop ? tx : reply;
        cp      = mode[1];
        edges   = 0;
        pulses  = 0;
        pulse_k = -1;
        prev_sck = 1'b0;
        bus_a.tx_data = tx;
        bus_a.cpol    = mode[1];
        bus_a.cpha    = mode[0];
        bus_a.ss_sel  = sel;
        fa_reply      = reply;
        fa_cpha       = mode[0];
        loop_a        = loop;
        bus_a.send    = 1'b1;
        for (int k = 1; k <= (2 * WA + 2) * HA + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus_a.send = 1'b0;
                check_output({tag, " busy@1"}, 32'(bus_a.busy), 32'd1);
                check_output({tag, " ss_n@1"}, 32'(bus_a.ss_n), 32'(exp_ssn));
                check_output({tag, " sck@1"}, 32'(bus_a.sck), 32'(cp));
                if (!mode[0]) check_output({tag, " mosi@1"}, 32'(bus_a.mosi), 32'(tx[7]));
                prev_sck = bus_a.sck;
            end else if (bus_a.sck != prev_sck) begin
                edges++;
                prev_sck = bus_a.sck;
            end
            if (k == 5) begin
                bus_a.tx_data = ~tx;
                bus_a.cpol    = ~mode[1];
                bus_a.cpha    = ~mode[0];
                bus_a.ss_sel  = sel + 2'd1;
            end
            if (k == HA) check_output({tag, " sck setup"}, 32'(bus_a.sck), 32'(cp));
            if (k == 2 * WA * HA + 2) check_output({tag, " sck hold"}, 32'(bus_a.sck), 32'(cp));
            if (k == 40) check_output({tag, " ss_n mid"}, 32'(bus_a.ss_n), 32'(exp_ssn));
            if (bus_a.rx_valid) begin
                pulses++;
                pulse_k = k;
                check_output({tag, " rx_data"}, 32'(bus_a.rx_data), 32'(exp_rx));
                check_output({tag, " ss_n done"}, 32'(bus_a.ss_n), 32'hF);
                check_output({tag, " busy done"}, 32'(bus_a.busy), 32'd0);
            end
        end
        check_output({tag, " pulses"}, 32'(pulses), 32'd1);
        check_output({tag, " pulse time"}, 32'(pulse_k), 32'(1 + (2 * WA + 1) * HA));
        check_output({tag, " edges"}, 32'(edges), 32'(2 * WA));
        check_output({tag, " follower rx"}, 32'(fa_rx), 32'(tx));
        check_output({tag, " sck idle"}, 32'(bus_a.sck), 32'(cp));
    endtask

    // One complete mode-0 loopback transfer on the 16-bit leader
    task automatic apply_stimulus_b(input logic [15:0] tx, input logic sel, input logic poke, input string tag);
        logic prev_sck;
        int   edges;
        int   pulses;
        int   pulse_k;
        int   stray;
        edges   = 0;
        pulses  = 0;
        pulse_k = -1;
        stray   = 0;
        prev_sck = 1'b0;
        bus_b.tx_data = tx;
        bus_b.cpol    = 1'b0;
        bus_b.cpha    = 1'b0;
        bus_b.ss_sel  = sel;
        bus_b.send    = 1'b1;
        for (int k = 1; k <= (2 * WB + 2) * HB + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus_b.send = 1'b0;
                check_output({tag, " busy@1"}, 32'(bus_b.busy), 32'd1);
                check_output({tag, " ss_n@1"}, 32'(bus_b.ss_n), (sel == 1'b0) ? 32'd0 : 32'd1);
                check_output({tag, " mosi@1"}, 32'(bus_b.mosi), 32'(tx[15]));
                prev_sck = bus_b.sck;
            end else if (bus_b.sck != prev_sck) begin
                edges++;
                prev_sck = bus_b.sck;
            end
            if (bus_b.rx_valid) begin
                pulses++;
                pulse_k = k;
                check_output({tag, " rx_data"}, 32'(bus_b.rx_data), 32'(tx));
                check_output({tag, " busy done"}, 32'(bus_b.busy), 32'd0);
            end
            if (poke && (k == 10 || k == 2 * WB * HB + 2 * HB)) bus_b.send = 1'b1;
            if (poke && (k == 11 || k == (2 * WB + 2) * HB + 1)) bus_b.send = 1'b0;
        end
        check_output({tag, " pulses"}, 32'(pulses), 32'd1);
        check_output({tag, " pulse time"}, 32'(pulse_k), 32'(1 + (2 * WB + 1) * HB));
        check_output({tag, " edges"}, 32'(edges), 32'(2 * WB));
        if (poke) begin
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                if (bus_b.busy || bus_b.rx_valid) stray++;
            end
            check_output({tag, " ignored sends"}, 32'(stray), 32'd0);
        end
    endtask

    initial begin : main
        vec_t       vecs[6];
        int         pk[3];
        logic [7:0] pd[3];
        logic       hist[0:239];
        int         np;
        int         gap;
        int         stray;
        logic [1:0] rsel;
        logic [1:0] rmode;
        logic [3:0] onehot;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        loop_a = 1'b0;
        fa_reply = '0;
        fa_cpha  = 1'b0;
        bus_a.tx_data = '0; bus_a.send = 1'b0; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0; bus_a.ss_sel = '0;
        bus_b.tx_data = '0; bus_b.send = 1'b0; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0; bus_b.ss_sel = '0;

        repeat (2) @(negedge clk);
        check_output("reset sck", 32'(bus_a.sck), 32'd0);
        check_output("reset ss_n", 32'(bus_a.ss_n), 32'hF);
        check_output("reset mosi", 32'(bus_a.mosi), 32'd0);
        check_output("reset rx_data", 32'(bus_a.rx_data), 32'd0);
        check_output("reset rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check_output("reset busy", 32'(bus_a.busy), 32'd0);
        check_output("reset b ss_n", 32'(bus_b.ss_n), 32'd1);
        check_output("reset b busy", 32'(bus_b.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors");
        vecs[0] = '{2'd0, 2'd0, 8'hA5, 8'h00, 1'b1, 4'b1110};
        vecs[1] = '{2'd1, 2'd0, 8'hC3, 8'h3C, 1'b0, 4'b1110};
        vecs[2] = '{2'd2, 2'd0, 8'hC3, 8'h3C, 1'b0, 4'b1110};
        vecs[3] = '{2'd3, 2'd0, 8'hC3, 8'h3C, 1'b0, 4'b1110};
        vecs[4] = '{2'd0, 2'd2, 8'h5A, 8'h81, 1'b0, 4'b1011};
        vecs[5] = '{2'd3, 2'd3, 8'h0F, 8'hE7, 1'b0, 4'b0111};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus_a(vecs[i].mode, vecs[i].sel, vecs[i].tx, vecs[i].reply, vecs[i].loop,
                             vecs[i].exp_ssn, $sformatf("vec%0d", i));
        end

        $display("[TB] back-to-back with send held");
        np = 0;
        for (int i = 0; i < 3; i++) begin pk[i] = -1; pd[i] = '0; end
        bus_a.tx_data = 8'h01; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0; bus_a.ss_sel = 2'd0;
        fa_cpha = 1'b0; loop_a = 1'b1; bus_a.send = 1'b1;
        hist[0] = 1'b1;
        for (int k = 1; k <= 230; k++) begin
            @(negedge clk);
            hist[k] = bus_a.ss_n[0];
            if (bus_a.rx_valid) begin
                if (np < 3) begin pk[np] = k; pd[np] = bus_a.rx_data; end
                np++;
            end
            if (k == 10) bus_a.tx_data = 8'h80;
            if (k == 83) bus_a.tx_data = 8'hFF;
            if (k == 150) bus_a.send = 1'b0;
        end
        gap = 0;
        for (int j = (pk[0] > 0) ? pk[0] : 1; j <= 230 && hist[j]; j++) gap++;
        check_output("b2b pulses", 32'(np), 32'd3);
        check_output("b2b first pulse", 32'(pk[0]), 32'(1 + (2 * WA + 1) * HA));
        check_output("b2b spacing 1", 32'(pk[1] - pk[0]), 32'((2 * WA + 2) * HA + 1));
        check_output("b2b spacing 2", 32'(pk[2] - pk[1]), 32'((2 * WA + 2) * HA + 1));
        check_output("b2b word 0", 32'(pd[0]), 32'h01);
        check_output("b2b word 1", 32'(pd[1]), 32'h80);
        check_output("b2b word 2", 32'(pd[2]), 32'hFF);
        check_output("b2b deselect", 32'(gap), 32'(HA + 1));

        $display("[TB] randomized transfers");
        for (int i = 0; i < 6; i++) begin
            rsel   = 2'($urandom_range(0, 3));
            rmode  = 2'($urandom_range(0, 3));
            onehot = 4'b0001 << rsel;
            apply_stimulus_a(rmode, rsel, 8'($urandom), 8'($urandom), 1'b0, ~onehot, $sformatf("rand%0d", i));
        end

        $display("[TB] reset mid-transfer");
        bus_a.tx_data = 8'h5A; bus_a.cpol = 1'b1; bus_a.cpha = 1'b0; bus_a.ss_sel = 2'd1;
        fa_cpha = 1'b0; loop_a = 1'b1; bus_a.send = 1'b1;
        for (int k = 1; k <= 1 + 7 * HA; k++) begin
            @(negedge clk);
            if (k == 1) bus_a.send = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_output("abort sck", 32'(bus_a.sck), 32'd0);
        check_output("abort ss_n", 32'(bus_a.ss_n), 32'hF);
        check_output("abort mosi", 32'(bus_a.mosi), 32'd0);
        check_output("abort busy", 32'(bus_a.busy), 32'd0);
        check_output("abort rx_data", 32'(bus_a.rx_data), 32'd0);
        check_output("abort rx_valid", 32'(bus_a.rx_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (bus_a.rx_valid || bus_a.busy) stray++;
        end
        check_output("abort no completion", 32'(stray), 32'd0);
        apply_stimulus_a(2'd3, 2'd1, 8'h96, 8'h69, 1'b0, 4'b1101, "after reset");

        $display("[TB] 16-bit leader");
        apply_stimulus_b(16'hBEEF, 1'b0, 1'b1, "w16 beef");
        apply_stimulus_b(16'($urandom), 1'b1, 1'b0, "w16 sel out of range");
        apply_stimulus_b(16'($urandom), 1'b0, 1'b0, "w16 rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
